// File: rtl/execution_stage_buffer_pkg.sv
// Shared constants for the EX->MEM buffer.
// Holds the default datapath widths and the payload bit layout.
// The layout, from LSB upward, is:
//   alu_zero | alu_result | destination_register | reg_write | mem_to_reg | immediate
// Offsets are functions of the widths so that every user of the layout derives
// it from a single place.
package execution_stage_buffer_pkg;

  localparam int WORD_WIDTH_DEF           = 32;
  localparam int REGISTER_INDEX_WIDTH_DEF = 5;

  localparam int OFF_ZERO   = 0;
  localparam int OFF_RESULT = 1;

  function automatic int off_rd(input int ww);
    return 1 + ww;
  endfunction

  function automatic int off_reg_write(input int ww, input int rw);
    return 1 + ww + rw;
  endfunction

  function automatic int off_mem_to_reg(input int ww, input int rw);
    return 2 + ww + rw;
  endfunction

  function automatic int off_imm(input int ww, input int rw);
    return 3 + ww + rw;
  endfunction

  function automatic int payload_w(input int ww, input int rw);
    return 2 * ww + rw + 3;
  endfunction

  localparam int PAYLOAD_W_DEF = 2 * WORD_WIDTH_DEF + REGISTER_INDEX_WIDTH_DEF + 3;

  // Pointer width; a single-entry queue still needs a 1-bit pointer.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ex_buffer_fifo.sv
// Generic circular FIFO holding the buffered EX results.
// Ports:
//   clk, reset (sync, active-high), flush (sync discard of all entries)
//   push / pop   : qualified write / read strobes from the top level
//   wdata        : entry written at wr_ptr on push
//   rdata        : head entry while non-empty, otherwise the last head shown
//   occupancy    : number of entries held (0..DEPTH)
// With EX_BUFFER_FORWARD_EN defined, the storage array and head pointer are
// also exported so the top level can scan entries for forwarding.
module ex_buffer_fifo
  import execution_stage_buffer_pkg::*;
#(
  parameter int WIDTH = PAYLOAD_W_DEF,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef EX_BUFFER_FORWARD_EN
  ,
  output logic [WIDTH-1:0]             entries [DEPTH],
  output logic [ptr_w(DEPTH)-1:0]      head_ptr
`endif
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] hold_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      hold_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      // Freeze the currently visible head so the outputs stop changing.
      if (count_q != '0) hold_q <= mem[rd_ptr];
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) begin
        hold_q <= mem[rd_ptr];
        rd_ptr <= next_ptr(rd_ptr);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // When empty the outputs keep showing the last head instead of a stale slot.
  assign rdata     = (count_q != '0) ? mem[rd_ptr] : hold_q;
  assign occupancy = count_q;

`ifdef EX_BUFFER_FORWARD_EN
  assign entries  = mem;
  assign head_ptr = rd_ptr;
`endif

endmodule

// File: rtl/execution_stage_buffer.sv
// EX->MEM pipeline buffer: queues up to DEPTH completed ALU results with
// valid/ready handshakes on both sides and a synchronous flush.
// Ports:
//   clk, reset (sync, active-high), flush
//   in_valid / in_ready   : upstream handshake, push = in_valid & in_ready
//   *_in                  : immediate, mem_to_reg, reg_write, rd, alu result, zero
//   out_valid / out_ready : downstream handshake, pop = out_valid & out_ready
//   *_out                 : head entry payload (qualify with out_valid)
//   occupancy             : entries held
// Optional feature macro EX_BUFFER_FORWARD_EN adds fwd_valid, fwd_register and
// fwd_result, exposing the youngest queued entry that writes a register with
// an ALU (non-load) result.
module execution_stage_buffer
  import execution_stage_buffer_pkg::*;
#(
  parameter int WORD_WIDTH           = WORD_WIDTH_DEF,
  parameter int REGISTER_INDEX_WIDTH = REGISTER_INDEX_WIDTH_DEF,
  parameter int DEPTH                = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WORD_WIDTH-1:0]           extended_inmediate_in,
  input  logic                            cu_mem_to_reg_in,
  input  logic                            cu_reg_write_in,
  input  logic [REGISTER_INDEX_WIDTH-1:0] destination_register_in,
  input  logic [WORD_WIDTH-1:0]           alu_result_in,
  input  logic                            alu_zero_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WORD_WIDTH-1:0]           extended_inmediate_out,
  output logic                            cu_mem_to_reg_out,
  output logic                            cu_reg_write_out,
  output logic [REGISTER_INDEX_WIDTH-1:0] destination_register_out,
  output logic [WORD_WIDTH-1:0]           alu_result_out,
  output logic                            alu_zero_out,
  output logic [$clog2(DEPTH+1)-1:0]      occupancy
`ifdef EX_BUFFER_FORWARD_EN
  ,
  output logic                            fwd_valid,
  output logic [REGISTER_INDEX_WIDTH-1:0] fwd_register,
  output logic [WORD_WIDTH-1:0]           fwd_result
`endif
);

  localparam int WW        = WORD_WIDTH;
  localparam int RW        = REGISTER_INDEX_WIDTH;
  localparam int PAYLOAD_W = payload_w(WW, RW);
  localparam int OFF_RD    = off_rd(WW);
  localparam int OFF_WR    = off_reg_write(WW, RW);
  localparam int OFF_M2R   = off_mem_to_reg(WW, RW);
  localparam int OFF_IMM   = off_imm(WW, RW);
  localparam int OCC_W     = $clog2(DEPTH + 1);

  logic                 push;
  logic                 pop;
  logic [PAYLOAD_W-1:0] wdata;
  logic [PAYLOAD_W-1:0] rdata;

  // No pass-through when full: a slot must be free before the edge.
  assign in_ready  = (occupancy != OCC_W'(DEPTH));
  assign out_valid = (occupancy != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign wdata = {extended_inmediate_in, cu_mem_to_reg_in, cu_reg_write_in,
                  destination_register_in, alu_result_in, alu_zero_in};

  assign alu_zero_out             = rdata[OFF_ZERO];
  assign alu_result_out           = rdata[OFF_RESULT +: WW];
  assign destination_register_out = rdata[OFF_RD +: RW];
  assign cu_reg_write_out         = rdata[OFF_WR];
  assign cu_mem_to_reg_out        = rdata[OFF_M2R];
  assign extended_inmediate_out   = rdata[OFF_IMM +: WW];

`ifdef EX_BUFFER_FORWARD_EN
  localparam int PTR_W = ptr_w(DEPTH);

  logic [PAYLOAD_W-1:0] entries [DEPTH];
  logic [PTR_W-1:0]     head_ptr;

  ex_buffer_fifo #(
    .WIDTH (PAYLOAD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .wdata     (wdata),
    .rdata     (rdata),
    .occupancy (occupancy),
    .entries   (entries),
    .head_ptr  (head_ptr)
  );

  // Physical slot of the k-th oldest entry.
  function automatic logic [PTR_W-1:0] slot(input logic [PTR_W-1:0] h, input int k);
    int s;
    s = int'(h) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd_valid    = 1'b0;
    fwd_register = '0;
    fwd_result   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < int'(occupancy) &&
          entries[slot(head_ptr, k)][OFF_WR] &&
          !entries[slot(head_ptr, k)][OFF_M2R]) begin
        fwd_valid    = 1'b1;
        fwd_register = entries[slot(head_ptr, k)][OFF_RD +: RW];
        fwd_result   = entries[slot(head_ptr, k)][OFF_RESULT +: WW];
      end
    end
  end
`else
  ex_buffer_fifo #(
    .WIDTH (PAYLOAD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .wdata     (wdata),
    .rdata     (rdata),
    .occupancy (occupancy)
  );
`endif

endmodule

// File: tb/tb_execution_stage_buffer.sv
// Self-checking bench for execution_stage_buffer (DEPTH=2, default widths).
// Expected payloads go to a scoreboard queue when a push is accepted and are
// compared when the buffer hands the head to a ready consumer.
module tb_execution_stage_buffer;

  typedef struct packed {
    logic [31:0] imm;
    logic        m2r;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        zero;
  } pl_t;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] val;
    logic [4:0]  rd;
    int          exp_occ;
    logic        exp_ov;
    logic        exp_ir;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] extended_inmediate_in;
  logic        cu_mem_to_reg_in;
  logic        cu_reg_write_in;
  logic [4:0]  destination_register_in;
  logic [31:0] alu_result_in;
  logic        alu_zero_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] extended_inmediate_out;
  logic        cu_mem_to_reg_out;
  logic        cu_reg_write_out;
  logic [4:0]  destination_register_out;
  logic [31:0] alu_result_out;
  logic        alu_zero_out;
  logic [1:0]  occupancy;
`ifdef EX_BUFFER_FORWARD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_register;
  logic [31:0] fwd_result;
`endif

  int  total = 0;
  int  bad   = 0;
  pl_t sb_q[$];
  vec_t vecs[13];

  execution_stage_buffer #(
    .WORD_WIDTH           (32),
    .REGISTER_INDEX_WIDTH (5),
    .DEPTH                (2)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .flush                    (flush),
    .in_valid                 (in_valid),
    .in_ready                 (in_ready),
    .extended_inmediate_in    (extended_inmediate_in),
    .cu_mem_to_reg_in         (cu_mem_to_reg_in),
    .cu_reg_write_in          (cu_reg_write_in),
    .destination_register_in  (destination_register_in),
    .alu_result_in            (alu_result_in),
    .alu_zero_in              (alu_zero_in),
    .out_valid                (out_valid),
    .out_ready                (out_ready),
    .extended_inmediate_out   (extended_inmediate_out),
    .cu_mem_to_reg_out        (cu_mem_to_reg_out),
    .cu_reg_write_out         (cu_reg_write_out),
    .destination_register_out (destination_register_out),
    .alu_result_out           (alu_result_out),
    .alu_zero_out             (alu_zero_out),
    .occupancy                (occupancy)
`ifdef EX_BUFFER_FORWARD_EN
    ,
    .fwd_valid                (fwd_valid),
    .fwd_register             (fwd_register),
    .fwd_result               (fwd_result)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic pl_t mk_pl(input logic [31:0] val, input logic [4:0] rd);
    pl_t p;
    p.imm  = val ^ 32'h5A5A_0000;
    p.m2r  = val[0];
    p.rw   = val[1];
    p.rd   = rd;
    p.res  = val;
    p.zero = val[2];
    return p;
  endfunction

  function automatic vec_t mk_vec(input logic iv, input logic ordy, input logic fl,
                                  input logic [31:0] val, input logic [4:0] rd,
                                  input int occ, input logic ov, input logic ir);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.val = val; v.rd = rd;
    v.exp_occ = occ; v.exp_ov = ov; v.exp_ir = ir;
    return v;
  endfunction

  task automatic drive(input logic iv, input pl_t p, input logic ordy, input logic fl);
    in_valid                = iv;
    extended_inmediate_in   = p.imm;
    cu_mem_to_reg_in        = p.m2r;
    cu_reg_write_in         = p.rw;
    destination_register_in = p.rd;
    alu_result_in           = p.res;
    alu_zero_in             = p.zero;
    out_ready               = ordy;
    flush                   = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: inputs are stable at the falling edge, so the handshakes seen
  // here are exactly the transfers of the following rising edge.
  always @(negedge clk) begin
    pl_t cur;
    pl_t exp;
    if (reset || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        cur = '{imm: extended_inmediate_out, m2r: cu_mem_to_reg_out, rw: cu_reg_write_out,
                rd: destination_register_out, res: alu_result_out, zero: alu_zero_out};
        if (sb_q.size() == 0) begin
          check("sb_unexpected_output", 128'(cur), 128'(0));
        end else begin
          exp = sb_q.pop_front();
          check("sb_payload", 128'(cur), 128'(exp));
        end
      end
      if (in_valid && in_ready)
        sb_q.push_back('{imm: extended_inmediate_in, m2r: cu_mem_to_reg_in, rw: cu_reg_write_in,
                         rd: destination_register_in, res: alu_result_in, zero: alu_zero_in});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pl_t p;
    // in_valid, out_ready, flush, value, rd -> occupancy, out_valid, in_ready after the edge
    vecs[0]  = mk_vec(1, 0, 0, 32'h0000_000A, 5'd1, 1, 1, 1);
    vecs[1]  = mk_vec(1, 0, 0, 32'h0000_000B, 5'd2, 2, 1, 0);
    vecs[2]  = mk_vec(1, 0, 0, 32'h0000_000C, 5'd3, 2, 1, 0);
    vecs[3]  = mk_vec(1, 1, 0, 32'h0000_000C, 5'd3, 1, 1, 1);
    vecs[4]  = mk_vec(1, 1, 0, 32'h0000_000C, 5'd3, 1, 1, 1);
    vecs[5]  = mk_vec(0, 1, 0, 32'h0000_0000, 5'd0, 0, 0, 1);
    vecs[6]  = mk_vec(1, 0, 0, 32'h0000_000D, 5'd4, 1, 1, 1);
    vecs[7]  = mk_vec(1, 0, 0, 32'h0000_000E, 5'd5, 2, 1, 0);
    vecs[8]  = mk_vec(1, 1, 1, 32'h0000_000F, 5'd6, 0, 0, 1);
    vecs[9]  = mk_vec(0, 1, 0, 32'h0000_0000, 5'd0, 0, 0, 1);
    vecs[10] = mk_vec(1, 1, 0, 32'h0000_0010, 5'd7, 1, 1, 1);
    vecs[11] = mk_vec(1, 1, 0, 32'hFFFF_FF26, 5'd31, 1, 1, 1);
    vecs[12] = mk_vec(0, 1, 0, 32'h0000_0000, 5'd0, 0, 0, 1);

    reset = 1'b1;
    drive(0, '0, 0, 0);
    step();
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_occupancy", 128'(occupancy), 128'(0));
    check("reset_alu_result", 128'(alu_result_out), 128'(0));
    check("reset_rd", 128'(destination_register_out), 128'(0));
    reset = 1'b0;

    // Single entry through with the consumer ready.
    drive(1, mk_pl(32'h0000_0011, 5'd3), 1, 0);
    step();
    check("single_out_valid", 128'(out_valid), 128'(1));
    check("single_alu_result", 128'(alu_result_out), 128'(32'h11));
    check("single_rd", 128'(destination_register_out), 128'(3));
    drive(0, '0, 1, 0);
    step();
    check("single_drained", 128'(out_valid), 128'(0));
    check("single_hold", 128'(alu_result_out), 128'(32'h11));

    // Fill, stall, push+pop, flush with concurrent push, refill.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].iv, mk_pl(vecs[i].val, vecs[i].rd), vecs[i].ordy, vecs[i].fl);
      step();
      check($sformatf("vec%0d_occupancy", i), 128'(occupancy), 128'(vecs[i].exp_occ));
      check($sformatf("vec%0d_out_valid", i), 128'(out_valid), 128'(vecs[i].exp_ov));
      check($sformatf("vec%0d_in_ready", i), 128'(in_ready), 128'(vecs[i].exp_ir));
    end

    // Reset in the middle of a stream drops everything and zeroes the outputs.
    drive(1, mk_pl(32'h0000_0033, 5'd9), 0, 0);
    step();
    drive(1, mk_pl(32'h0000_0044, 5'd10), 0, 0);
    step();
    check("midreset_full", 128'(occupancy), 128'(2));
    drive(0, '0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_occupancy", 128'(occupancy), 128'(0));
    check("midreset_out_valid", 128'(out_valid), 128'(0));
    check("midreset_in_ready", 128'(in_ready), 128'(1));
    check("midreset_alu_result", 128'(alu_result_out), 128'(0));

`ifdef EX_BUFFER_FORWARD_EN
    p = '{imm: 32'h0, m2r: 1'b0, rw: 1'b1, rd: 5'd5, res: 32'h1, zero: 1'b0};
    drive(1, p, 0, 0);
    step();
    check("fwd_first_valid", 128'(fwd_valid), 128'(1));
    check("fwd_first_result", 128'(fwd_result), 128'(1));
    p.res = 32'h2;
    drive(1, p, 0, 0);
    step();
    drive(0, '0, 0, 0);
    #1;
    check("fwd_valid", 128'(fwd_valid), 128'(1));
    check("fwd_register", 128'(fwd_register), 128'(5));
    check("fwd_result", 128'(fwd_result), 128'(2));
    drive(0, '0, 0, 1);
    step();
    drive(0, '0, 0, 0);
    check("fwd_after_flush", 128'(fwd_valid), 128'(0));
    check("fwd_flush_occupancy", 128'(occupancy), 128'(0));
`else
    p = '0;
    drive(0, p, 0, 0);
`endif

    step();
    check("sb_drained", 128'(sb_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
